// File: rtl/vga_axil_slave.sv
// vga_axil_slave: AXI4-Lite responder feeding the VGA core sideband; define VGA_AXIL_ADDR_CHECK_EN for address decode with SLVERR
module vga_axil_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 15,
  parameter int HOLD_CYCLES      = 3,
  parameter int RD_LATENCY       = 2
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  output logic [1:0]                    s_axil_bresp,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic [C_AXI_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          axil_wready_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
  output logic                          axil_rreq_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_HOLD, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rstate_e;

  wstate_e       wstate_q, wstate_d;
  rstate_e       rstate_q, rstate_d;
  logic          aw_got_q, aw_got_d;
  logic          w_got_q, w_got_d;
  logic          aw_bad_q, aw_bad_d;
  logic [2:0]    hcnt_q, hcnt_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          aw_hs, w_hs, ar_hs;
  logic          aw_bad, ar_bad;

`ifdef VGA_AXIL_ADDR_CHECK_EN
  // Text buffer ends at 0x0960 in the upper half; register word 7 is unmapped
  function automatic logic addr_bad(input logic [AW-1:0] a);
    return (a[14] && (a[13:0] >= 14'h0960)) || ((a[14:13] == 2'b01) && (a[4:2] == 3'b111));
  endfunction
  assign aw_bad = addr_bad(s_axil_awaddr);
  assign ar_bad = addr_bad(s_axil_araddr);
`else
  assign aw_bad = 1'b0;
  assign ar_bad = 1'b0;
`endif

  assign s_axil_awready = (wstate_q == W_IDLE) && !aw_got_q;
  assign s_axil_wready  = (wstate_q == W_IDLE) && !w_got_q;
  assign s_axil_arready = (rstate_q == R_IDLE);
  assign aw_hs          = s_axil_awvalid && s_axil_awready;
  assign w_hs           = s_axil_wvalid && s_axil_wready;
  assign ar_hs          = s_axil_arvalid && s_axil_arready;

  assign s_axil_bvalid = (wstate_q == W_RESP);
  assign s_axil_bresp  = bresp_q;
  assign axil_wready_o = (wstate_q == W_ISSUE);
  assign axil_waddr_o  = waddr_q;
  assign axil_wdata_o  = wdata_q;
  assign axil_wstrb_o  = wstrb_q;
  assign s_axil_rvalid = (rstate_q == R_RESP);
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign axil_rreq_o   = (rstate_q == R_REQ);
  assign axil_raddr_o  = raddr_q;

  // Write path: collect AW and W in any order, strobe the core, hold, then respond
  always_comb begin
    wstate_d = wstate_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    aw_bad_d = aw_bad_q;
    hcnt_d   = hcnt_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          aw_bad_d = aw_bad;
          waddr_d  = s_axil_awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axil_wdata;
          wstrb_d = s_axil_wstrb;
        end
        if (aw_got_d && w_got_d) begin
          wstate_d = aw_bad_d ? W_RESP : W_ISSUE;
          bresp_d  = aw_bad_d ? 2'b10 : 2'b00;
        end
      end
      W_ISSUE: begin
        wstate_d = W_HOLD;
        hcnt_d   = 3'(HOLD_CYCLES - 1);
      end
      W_HOLD: begin
        if (hcnt_q == 3'd0) wstate_d = W_RESP;
        else hcnt_d = hcnt_q - 3'd1;
      end
      W_RESP: begin
        if (s_axil_bready) begin
          wstate_d = W_IDLE;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read path: latch address, pulse request, wait for the core, then respond
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d  = s_axil_araddr;
          rstate_d = ar_bad ? R_RESP : R_REQ;
          rresp_d  = ar_bad ? 2'b10 : 2'b00;
          rdata_d  = ar_bad ? '0 : rdata_q;
        end
      end
      R_REQ: begin
        rstate_d = R_WAIT;
        rcnt_d   = 3'(RD_LATENCY - 1);
      end
      R_WAIT: begin
        if (rcnt_q == 3'd0) begin
          rdata_d  = axil_rdata_i;
          rstate_d = R_RESP;
        end else rcnt_d = rcnt_q - 3'd1;
      end
      R_RESP: if (s_axil_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      aw_bad_q <= 1'b0;
      hcnt_q   <= '0;
      rcnt_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= 2'b00;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      aw_bad_q <= aw_bad_d;
      hcnt_q   <= hcnt_d;
      rcnt_q   <= rcnt_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_vga_axil_slave.sv
// tb_vga_axil_slave: directed checks of the AXI-lite to VGA sideband bridge
module tb_vga_axil_slave;
  logic        clk_i = 1'b0, rstn_i = 1'b0;
  logic        s_axil_awvalid = 1'b0, s_axil_awready;
  logic [14:0] s_axil_awaddr = '0;
  logic        s_axil_wvalid = 1'b0, s_axil_wready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_bvalid, s_axil_bready = 1'b0;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_arvalid = 1'b0, s_axil_arready;
  logic [14:0] s_axil_araddr = '0;
  logic        s_axil_rvalid, s_axil_rready = 1'b0;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        axil_wready_o, axil_rreq_o;
  logic [14:0] axil_waddr_o, axil_raddr_o;
  logic [31:0] axil_wdata_o, axil_rdata_i = '0;
  logic [3:0]  axil_wstrb_o;
  int n_chk = 0, n_pass = 0;

  vga_axil_slave dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awaddr(s_axil_awaddr),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_wdata(s_axil_wdata),
    .s_axil_wstrb(s_axil_wstrb), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_bresp(s_axil_bresp), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_araddr(s_axil_araddr), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .axil_wready_o(axil_wready_o),
    .axil_waddr_o(axil_waddr_o), .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
    .axil_rreq_o(axil_rreq_o), .axil_raddr_o(axil_raddr_o), .axil_rdata_i(axil_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic put_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axil_awvalid = 1'b1;
    s_axil_awaddr  = a;
    s_axil_wvalid  = 1'b1;
    s_axil_wdata   = d;
    s_axil_wstrb   = s;
  endtask

  task automatic take_b();
    s_axil_bready = 1'b1;
    step(1);
    s_axil_bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    step(2);
    rstn_i = 1'b1;
    step(1);
    chk("rst awready", s_axil_awready, 1);
    chk("rst wready", s_axil_wready, 1);
    chk("rst arready", s_axil_arready, 1);
    chk("rst bvalid", s_axil_bvalid, 0);
    chk("rst rvalid", s_axil_rvalid, 0);
    chk("rst wready_o", axil_wready_o, 0);
    chk("rst rreq", axil_rreq_o, 0);
    chk("rst waddr", axil_waddr_o, 0);
    // same-cycle AW+W
    put_write(15'h2004, 32'h5, 4'hF);
    step(1);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    chk("t1 wready_o T+1", axil_wready_o, 1);
    chk("t1 waddr T+1", axil_waddr_o, 32'h2004);
    chk("t1 wdata T+1", axil_wdata_o, 32'h5);
    chk("t1 wstrb T+1", axil_wstrb_o, 4'hF);
    chk("t1 awready busy", s_axil_awready, 0);
    step(1);
    chk("t1 wready_o T+2", axil_wready_o, 0);
    chk("t1 waddr T+2", axil_waddr_o, 32'h2004);
    step(2);
    chk("t1 bvalid T+4", s_axil_bvalid, 0);
    chk("t1 wdata T+4", axil_wdata_o, 32'h5);
    step(1);
    chk("t1 bvalid T+5", s_axil_bvalid, 1);
    chk("t1 bresp", s_axil_bresp, 2'b00);
    take_b();
    chk("t1 bvalid after", s_axil_bvalid, 0);
    chk("t1 awready after", s_axil_awready, 1);
    // W three cycles ahead of AW
    s_axil_wvalid = 1'b1;
    s_axil_wdata  = 32'hDEADBEEF;
    s_axil_wstrb  = 4'h3;
    step(1);
    s_axil_wvalid = 1'b0;
    chk("t2 wready latched", s_axil_wready, 0);
    chk("t2 awready open", s_axil_awready, 1);
    chk("t2 wdata early", axil_wdata_o, 32'hDEADBEEF);
    chk("t2 no strobe yet", axil_wready_o, 0);
    step(2);
    s_axil_awvalid = 1'b1;
    s_axil_awaddr  = 15'h4000;
    step(1);
    s_axil_awvalid = 1'b0;
    chk("t2 wready_o", axil_wready_o, 1);
    chk("t2 waddr", axil_waddr_o, 32'h4000);
    chk("t2 wstrb", axil_wstrb_o, 4'h3);
    step(4);
    chk("t2 bvalid", s_axil_bvalid, 1);
    // backpressure on B with a new write waiting
    put_write(15'h0123, 32'h12345678, 4'hC);
    for (int i = 0; i < 6; i++) begin
      chk("t4 bvalid held", s_axil_bvalid, 1);
      chk("t4 bresp held", s_axil_bresp, 2'b00);
      chk("t4 awready blocked", s_axil_awready, 0);
      chk("t4 wready blocked", s_axil_wready, 0);
      step(1);
    end
    chk("t4 waddr unchanged", axil_waddr_o, 32'h4000);
    take_b();
    chk("t4 single b", s_axil_bvalid, 0);
    chk("t4 awready reopen", s_axil_awready, 1);
    step(1);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    chk("t4 wready_o", axil_wready_o, 1);
    chk("t4 waddr", axil_waddr_o, 32'h0123);
    chk("t4 wdata", axil_wdata_o, 32'h12345678);
    step(4);
    chk("t4 bvalid", s_axil_bvalid, 1);
    take_b();
    // read with two-cycle core latency
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 15'h2000;
    step(1);
    s_axil_arvalid = 1'b0;
    chk("t3 rreq T+1", axil_rreq_o, 1);
    chk("t3 raddr T+1", axil_raddr_o, 32'h2000);
    chk("t3 arready busy", s_axil_arready, 0);
    step(1);
    axil_rdata_i = 32'hA;
    chk("t3 rreq T+2", axil_rreq_o, 0);
    chk("t3 rvalid T+2", s_axil_rvalid, 0);
    step(1);
    chk("t3 rvalid T+3", s_axil_rvalid, 0);
    chk("t3 raddr T+3", axil_raddr_o, 32'h2000);
    step(1);
    axil_rdata_i = 32'h55;
    chk("t3 rvalid T+4", s_axil_rvalid, 1);
    chk("t3 rdata", s_axil_rdata, 32'hA);
    chk("t3 rresp", s_axil_rresp, 2'b00);
    step(1);
    chk("t3 rdata held", s_axil_rdata, 32'hA);
    s_axil_rready = 1'b1;
    step(1);
    s_axil_rready = 1'b0;
    chk("t3 rvalid done", s_axil_rvalid, 0);
    chk("t3 arready reopen", s_axil_arready, 1);
    // overlapping read and write
    put_write(15'h0010, 32'hCAFE, 4'h1);
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 15'h0014;
    step(1);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_arvalid = 1'b0;
    chk("ov wready_o", axil_wready_o, 1);
    chk("ov rreq", axil_rreq_o, 1);
    step(3);
    chk("ov rvalid T+4", s_axil_rvalid, 1);
    chk("ov rdata", s_axil_rdata, 32'h55);
    chk("ov bvalid T+4", s_axil_bvalid, 0);
    step(1);
    chk("ov bvalid T+5", s_axil_bvalid, 1);
    s_axil_rready = 1'b1;
    take_b();
    s_axil_rready = 1'b0;
    // asynchronous reset during the hold phase
    put_write(15'h1008, 32'h77, 4'hF);
    step(1);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    step(1);
    rstn_i = 1'b0;
    #1;
    chk("t5 waddr reset", axil_waddr_o, 0);
    chk("t5 wdata reset", axil_wdata_o, 0);
    chk("t5 bvalid reset", s_axil_bvalid, 0);
    chk("t5 wready_o reset", axil_wready_o, 0);
    step(1);
    rstn_i = 1'b1;
    step(1);
    chk("t5 awready release", s_axil_awready, 1);
    chk("t5 wready release", s_axil_wready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("t5 no bvalid", s_axil_bvalid, 0);
      step(1);
    end
    // write beyond the text buffer
    put_write(15'h4960, 32'h99, 4'hF);
    step(1);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
`ifdef VGA_AXIL_ADDR_CHECK_EN
    chk("t6 no wready_o", axil_wready_o, 0);
    chk("t6 bvalid", s_axil_bvalid, 1);
    chk("t6 bresp", s_axil_bresp, 2'b10);
`else
    chk("t6 wready_o", axil_wready_o, 1);
    step(4);
    chk("t6 bvalid", s_axil_bvalid, 1);
    chk("t6 bresp", s_axil_bresp, 2'b00);
`endif
    take_b();
    chk("t6 bvalid done", s_axil_bvalid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
